ram_sync_read_be: RTL and testbench

- Parameterised single-port synchronous-read RAM; the next generation of the team's data-RAM blocks.
- Adds per-byte write enables, a request/response handshake, and a configurable read latency of 1 or 2.
- Adds selectable read-during-write behaviour and a post-reset memory-clear sequencer.
- Sits between datapath state engines and on-chip storage wherever a clean power-up memory image and partial-word updates are needed.

---
 rtl/ram_cfg_pkg.sv | 28 ++
 rtl/ram_init_seq.sv | 47 ++++
 rtl/ram_sync_read_be.sv | 117 +++++++++++
 tb/tb_ram_sync_read_be.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_cfg_pkg.sv
// rtl/ram_cfg_pkg.sv - shared types, constants and byte-merge helper for the sync-read RAM
package ram_cfg_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } init_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the merge helper handles; callers zero-extend and truncate around it.
    localparam int MERGE_DW = 256;

    function automatic logic [MERGE_DW-1:0] byte_merge(
        input logic [MERGE_DW-1:0] old_word,
        input logic [MERGE_DW-1:0] new_word,
        input logic [MERGE_DW-1:0] be,
        input int unsigned         bwidth
    );
        logic [MERGE_DW-1:0] merged;
        for (int i = 0; i < MERGE_DW; i++) begin
            merged[i] = be[8'(i / bwidth)] ? new_word[i] : old_word[i];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_init_seq.sv
// rtl/ram_init_seq.sv - post-reset clear counter and CLEAR/RUN state machine
module ram_init_seq
    import ram_cfg_pkg::*;
#(
    parameter int AWIDTH     = 3,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              clr_we,
    output logic [AWIDTH-1:0] clr_addr,
    output logic              init_done
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

    init_state_t state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_CLEAR;
            clr_addr  <= '0;
            clr_we    <= (INIT_CLEAR != 0);
            init_done <= 1'b0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    // With the clear disabled clr_we is never set, so this leaves on the first edge.
                    if (!clr_we || clr_addr == LAST_ADDR) begin
                        state     <= ST_RUN;
                        clr_we    <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done <= 1'b1;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_sync_read_be.sv
// rtl/ram_sync_read_be.sv - single-port sync-read RAM with byte enables, clear sequencer and 1/2-cycle latency
module ram_sync_read_be
    import ram_cfg_pkg::*;
#(
    parameter int              AWIDTH     = 3,
    parameter int              DWIDTH     = 32,
    parameter int              BWIDTH     = 8,
    parameter int              RD_LATENCY = 1,
    parameter int              RDW_MODE   = 0,
    parameter int              INIT_CLEAR = 1,
    parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     we,
    input  logic [AWIDTH-1:0]        addr,
    input  logic [DWIDTH-1:0]        din,
    input  logic [DWIDTH/BWIDTH-1:0] be,
    output logic                     ready,
    output logic [DWIDTH-1:0]        dout,
    output logic                     dout_valid,
    output logic                     init_done
);

    localparam int DEPTH = 1 << AWIDTH;

    generate
        if ((DWIDTH % BWIDTH) != 0 || (RD_LATENCY != 1 && RD_LATENCY != 2) || DWIDTH > MERGE_DW) begin : g_bad_param
            $error("ram_sync_read_be: illegal DWIDTH/BWIDTH/RD_LATENCY combination");
        end
    endgenerate

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              clr_we;
    logic [AWIDTH-1:0] clr_addr;

    ram_init_seq #(
        .AWIDTH     (AWIDTH),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_init_seq (
        .clock     (clock),
        .reset     (reset),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    assign ready = init_done;

    logic              accept;
    logic [DWIDTH-1:0] old_word;
    logic [DWIDTH-1:0] merged_word;
    logic [DWIDTH-1:0] resp_data;

    assign accept      = req & ready;
    assign old_word    = mem[addr];
    assign merged_word = DWIDTH'(byte_merge(MERGE_DW'(old_word), MERGE_DW'(din), MERGE_DW'(be), BWIDTH));

    always_comb begin
        resp_data = old_word;
        if (we && RDW_MODE == RDW_NEW) begin
            resp_data = merged_word;
        end
    end

    // Clear and user writes never overlap: ready stays low for the whole clear.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VALUE;
        end else if (accept && we) begin
            mem[addr] <= merged_word;
        end
    end

    logic              s1_valid;
    logic [DWIDTH-1:0] s1_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= resp_data;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              s2_valid;
            logic [DWIDTH-1:0] s2_data;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign dout       = s2_data;
            assign dout_valid = s2_valid;
        end else begin : g_lat1
            assign dout       = s1_data;
            assign dout_valid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sync_read_be.sv
// tb/tb_ram_sync_read_be.sv - self-checking bench: latency-1 read-first and latency-2 write-first instances
module tb_ram_sync_read_be;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [2:0]  addr  = '0;
    logic [31:0] din   = '0;
    logic [3:0]  be    = '0;

    logic        ready0, dout_valid0, init_done0;
    logic [31:0] dout0;
    logic        ready1, dout_valid1, init_done1;
    logic [31:0] dout1;

    localparam logic [31:0] INIT = 32'hDEADBEEF;

    ram_sync_read_be #(
        .AWIDTH(3), .DWIDTH(32), .BWIDTH(8), .RD_LATENCY(1), .RDW_MODE(0),
        .INIT_CLEAR(1), .INIT_VALUE(INIT)
    ) u_dut0 (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .din(din), .be(be),
        .ready(ready0), .dout(dout0), .dout_valid(dout_valid0), .init_done(init_done0)
    );

    ram_sync_read_be #(
        .AWIDTH(3), .DWIDTH(32), .BWIDTH(8), .RD_LATENCY(2), .RDW_MODE(1),
        .INIT_CLEAR(1), .INIT_VALUE(INIT)
    ) u_dut1 (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .din(din), .be(be),
        .ready(ready1), .dout(dout1), .dout_valid(dout_valid1), .init_done(init_done1)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        w;
        logic [2:0]  a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp_old;
        logic [31:0] exp_new;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    vec_t tbl[14];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit tb_run   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_port(input int k, input logic v, input logic [31:0] d);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (k == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
        if (v) begin
            if (!have) begin
                chk($sformatf("unexpected_valid%0d", k), 32'(v), 32'd0);
            end else begin
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                chk($sformatf("data%0d", k), d, e.data);
                chk($sformatf("latency%0d", k), cyc, e.due);
            end
        end else if (have && e.due <= cyc) begin
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            chk($sformatf("missing_valid%0d", k), 32'(v), 32'd1);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        @(negedge clock);
        check_port(0, dout_valid0, dout0);
        check_port(1, dout_valid1, dout1);
    endtask

    task automatic drive(input logic w, input logic [2:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] eo, input logic [31:0] en);
        req = 1'b1; we = w; addr = a; din = d; be = b;
        if (tb_run) begin
            q0.push_back('{eo, cyc + 1});
            q1.push_back('{en, cyc + 2});
        end
        tick();
    endtask

    task automatic idle(input int n);
        req = 1'b0; we = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready0"}, 32'(ready0), 32'd0);
        chk({tag, "_valid0"}, 32'(dout_valid0), 32'd0);
        chk({tag, "_dout0"}, dout0, 32'd0);
        chk({tag, "_done0"}, 32'(init_done0), 32'd0);
        chk({tag, "_ready1"}, 32'(ready1), 32'd0);
        chk({tag, "_valid1"}, 32'(dout_valid1), 32'd0);
        chk({tag, "_dout1"}, dout1, 32'd0);
        chk({tag, "_done1"}, 32'(init_done1), 32'd0);
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (n < 20 && !(ready0 && ready1)) begin
            tick();
            n++;
        end
        chk({tag, "_cycles"}, n, 32'd8);
        chk({tag, "_done0"}, 32'(init_done0), 32'd1);
        chk({tag, "_done1"}, 32'(init_done1), 32'd1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 3'd3, 32'hAABBCCDD, 4'b1111, INIT,         32'hAABBCCDD};
        tbl[1]  = '{1'b1, 3'd3, 32'h11223344, 4'b0101, 32'hAABBCCDD, 32'hAA22CC44};
        tbl[2]  = '{1'b0, 3'd3, 32'h0,        4'b0000, 32'hAA22CC44, 32'hAA22CC44};
        tbl[3]  = '{1'b1, 3'd5, 32'h00000000, 4'b1111, INIT,         32'h00000000};
        tbl[4]  = '{1'b1, 3'd5, 32'h12345678, 4'b1111, 32'h00000000, 32'h12345678};
        tbl[5]  = '{1'b0, 3'd5, 32'h0,        4'b1111, 32'h12345678, 32'h12345678};
        tbl[6]  = '{1'b1, 3'd6, 32'hCAFEF00D, 4'b0000, INIT,         INIT};
        tbl[7]  = '{1'b0, 3'd6, 32'h0,        4'b0000, INIT,         INIT};
        tbl[8]  = '{1'b1, 3'd0, 32'h0000AB00, 4'b0010, INIT,         32'hDEADABEF};
        tbl[9]  = '{1'b0, 3'd0, 32'h0,        4'b0000, 32'hDEADABEF, 32'hDEADABEF};
        tbl[10] = '{1'b0, 3'd1, 32'h0,        4'b0000, INIT,         INIT};
        tbl[11] = '{1'b0, 3'd2, 32'h0,        4'b0000, INIT,         INIT};
        tbl[12] = '{1'b1, 3'd7, 32'h01000000, 4'b1000, INIT,         32'h01ADBEEF};
        tbl[13] = '{1'b0, 3'd7, 32'h0,        4'b0000, 32'h01ADBEEF, 32'h01ADBEEF};

        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("por");

        // A write held during the clear must be ignored and must not respond.
        req = 1'b1; we = 1'b1; addr = 3'd0; din = 32'hFFFFFFFF; be = 4'hF;
        reset = 1'b0;
        wait_clear("clear0");
        req = 1'b0; we = 1'b0;
        tb_run = 1'b1;

        for (int a = 0; a < 8; a++) drive(1'b0, 3'(a), 32'h0, 4'h0, INIT, INIT);
        idle(3);

        for (int i = 0; i < 14; i++)
            drive(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b, tbl[i].exp_old, tbl[i].exp_new);
        idle(4);
        chk("hold0", dout0, 32'h01ADBEEF);
        chk("hold1", dout1, 32'h01ADBEEF);

        // Reset with the latency-2 read still in flight.
        drive(1'b0, 3'd3, 32'h0, 4'h0, 32'hAA22CC44, 32'hAA22CC44);
        reset = 1'b1; req = 1'b0;
        #1;
        check_reset_outputs("rst_pipe");
        q0.delete(); q1.delete();
        tb_run = 1'b0;
        tick();
        chk("inflight_valid1", 32'(dout_valid1), 32'd0);
        tick();
        reset = 1'b0;

        // Reset again once the clear has reached address 4.
        repeat (4) tick();
        chk("mid_clear_ready0", 32'(ready0), 32'd0);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_clear");
        tick();
        reset = 1'b0;
        wait_clear("clear1");
        tb_run = 1'b1;

        drive(1'b0, 3'd3, 32'h0, 4'h0, INIT, INIT);
        drive(1'b0, 3'd7, 32'h0, 4'h0, INIT, INIT);
        drive(1'b0, 3'd0, 32'h0, 4'h0, INIT, INIT);
        idle(4);
        chk("drained0", q0.size(), 32'd0);
        chk("drained1", q1.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
